vga_stream_monitor: RTL and testbench

Passive receiver for the pipelined XVGA pixel stream that the display writer emits (phsync, pvsync, pblank, 24-bit pixel). It rebuilds pixel coordinates from the sync and blank edges, checks line and frame geometry, and counts rover-red and target-green pixels. It also samples one probe pixel and publishes a per-frame result record over a valid/ready handshake. The block sits beside the VGA output in the main FPGA as a self-check and debug tap, and drives nothing back into the video path.

---
 rtl/vga_mon_pkg.sv | 26 ++
 rtl/crc16_px24.sv | 21 ++
 rtl/vga_stream_monitor.sv | 183 ++++++++++++++++++
 tb/tb_vga_stream_monitor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mon_pkg.sv
// Shared types and constants for the VGA stream monitor: FSM states, XVGA geometry,
// counter width and the CRC-16-CCITT parameters.
package vga_mon_pkg;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    FRAME     = 2'd1,
    PUBLISH   = 2'd2
  } mon_state_e;

  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;
  localparam int H_TOTAL  = 1344;
  localparam int V_TOTAL  = 806;

  // Coordinate counters are sized to cover the full raster, not just the active area.
  localparam int X_W = $clog2(H_TOTAL);
  localparam int Y_W = $clog2(V_TOTAL);

  localparam int               CNT_W   = 20;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/crc16_px24.sv
// Combinational CRC-16-CCITT update over one 24-bit pixel, MSB (bit 23) first.
module crc16_px24
  import vga_mon_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [23:0] data,
  output logic [15:0] crc_out
);

  logic [15:0] crc_w;

  always_comb begin
    crc_w = crc_in;
    for (int i = 23; i >= 0; i--) begin
      if (crc_w[15] ^ data[i]) crc_w = {crc_w[14:0], 1'b0} ^ CRC_POLY;
      else                     crc_w = {crc_w[14:0], 1'b0};
    end
    crc_out = crc_w;
  end

endmodule

// File: rtl/vga_stream_monitor.sv
// Passive XVGA stream monitor: rebuilds coordinates, checks geometry, counts colours,
// samples a probe pixel and publishes one record per frame. CRC gated by VGA_MON_CRC_EN.
module vga_stream_monitor
  import vga_mon_pkg::*;
#(
  parameter int          EXP_WIDTH   = H_ACTIVE,
  parameter int          EXP_HEIGHT  = V_ACTIVE,
  parameter logic [23:0] RED_COLOR   = 24'hFF_00_00,
  parameter logic [23:0] GREEN_COLOR = 24'h00_FF_00
) (
  input  logic             vclock,
  input  logic             reset_n,
  input  logic             phsync,
  input  logic             pvsync,
  input  logic             pblank,
  input  logic [23:0]      pixel,
  input  logic [X_W-1:0]   probe_x,
  input  logic [Y_W-1:0]   probe_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [X_W-1:0]   res_width,
  output logic [Y_W-1:0]   res_height,
  output logic [CNT_W-1:0] res_red_cnt,
  output logic [CNT_W-1:0] res_green_cnt,
  output logic [23:0]      res_probe,
  output logic             res_geom_err,
  output logic             res_overrun,
  output logic [15:0]      res_crc,
  output mon_state_e       dbg_state
);

  localparam logic [X_W-1:0] EXP_W = X_W'(EXP_WIDTH);
  localparam logic [Y_W-1:0] EXP_H = Y_W'(EXP_HEIGHT);

  logic             s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_blank_q, s1_blank_d;
  logic [23:0]      s1_pix_q, s1_pix_d;
  logic             s2_hs_q, s2_hs_d, s2_vs_q, s2_vs_d, s2_blank_q, s2_blank_d;
  mon_state_e       state_q, state_d;
  logic [X_W-1:0]   x_q, x_d, width_q, width_d, px_q, px_d;
  logic [Y_W-1:0]   y_q, y_d, py_q, py_d;
  logic [CNT_W-1:0] red_q, red_d, green_q, green_d;
  logic [23:0]      probe_q, probe_d;
  logic             gerr_q, gerr_d;
  logic             res_valid_q, res_valid_d, res_gerr_q, res_gerr_d, res_ovr_q, res_ovr_d;
  logic [X_W-1:0]   res_width_q, res_width_d;
  logic [Y_W-1:0]   res_height_q, res_height_d;
  logic [CNT_W-1:0] res_red_q, res_red_d, res_green_q, res_green_d;
  logic [23:0]      res_probe_q, res_probe_d;

  logic hs_fall, vs_fall, line_end, active;

  assign hs_fall  = s2_hs_q & ~s1_hs_q;
  assign vs_fall  = s2_vs_q & ~s1_vs_q;
  assign line_end = ~s2_blank_q & s1_blank_q;
  assign active   = ~s1_blank_q;

  // Result handshake: a record is held stable while res_valid=1 until a cycle with
  // res_valid & res_ready; a PUBLISH always loads and keeps res_valid high, flagging
  // overrun only if the record it replaces was still pending and not taken that cycle.
  always_comb begin
    s1_hs_d = phsync;  s1_vs_d = pvsync;  s1_blank_d = pblank;  s1_pix_d = pixel;
    s2_hs_d = s1_hs_q; s2_vs_d = s1_vs_q; s2_blank_d = s1_blank_q;
    state_d = state_q;
    x_d = x_q; y_d = y_q; width_d = width_q; px_d = px_q; py_d = py_q;
    red_d = red_q; green_d = green_q; probe_d = probe_q; gerr_d = gerr_q;
    res_valid_d = res_valid_q; res_gerr_d = res_gerr_q; res_ovr_d = res_ovr_q;
    res_width_d = res_width_q; res_height_d = res_height_q;
    res_red_d = res_red_q; res_green_d = res_green_q; res_probe_d = res_probe_q;

    if (hs_fall)     x_d = '0;
    else if (active) x_d = x_q + 1'b1;

    case (state_q)
      SYNC_WAIT: begin
        if (vs_fall) begin
          state_d = FRAME;
          px_d    = probe_x;
          py_d    = probe_y;
        end
      end
      FRAME: begin
        if (active) begin
          if (s1_pix_q == RED_COLOR && red_q != CNT_MAX)     red_d   = red_q + 1'b1;
          if (s1_pix_q == GREEN_COLOR && green_q != CNT_MAX) green_d = green_q + 1'b1;
          if (x_q == px_q && y_q == py_q)                    probe_d = s1_pix_q;
        end
        if (line_end) begin
          y_d     = y_q + 1'b1;
          width_d = x_q;
          if (x_q != EXP_W) gerr_d = 1'b1;
        end
        if (vs_fall) state_d = PUBLISH;
      end
      PUBLISH: begin
        res_valid_d  = 1'b1;
        res_ovr_d    = res_valid_q & ~res_ready;
        res_width_d  = width_q;
        res_height_d = y_q;
        res_red_d    = red_q;
        res_green_d  = green_q;
        res_probe_d  = probe_q;
        res_gerr_d   = gerr_q | (y_q != EXP_H);
        y_d = '0; width_d = '0; red_d = '0; green_d = '0; probe_d = '0; gerr_d = 1'b0;
        px_d    = probe_x;
        py_d    = probe_y;
        state_d = FRAME;
      end
      default: state_d = SYNC_WAIT;
    endcase

    if (state_q != PUBLISH && res_valid_q && res_ready) res_valid_d = 1'b0;
  end

  always_ff @(posedge vclock) begin
    if (!reset_n) begin
      s1_hs_q <= 1'b1; s1_vs_q <= 1'b1; s1_blank_q <= 1'b1; s1_pix_q <= '0;
      s2_hs_q <= 1'b1; s2_vs_q <= 1'b1; s2_blank_q <= 1'b1;
      state_q <= SYNC_WAIT;
      x_q <= '0; y_q <= '0; width_q <= '0; px_q <= '0; py_q <= '0;
      red_q <= '0; green_q <= '0; probe_q <= '0; gerr_q <= 1'b0;
      res_valid_q <= 1'b0; res_gerr_q <= 1'b0; res_ovr_q <= 1'b0;
      res_width_q <= '0; res_height_q <= '0;
      res_red_q <= '0; res_green_q <= '0; res_probe_q <= '0;
    end else begin
      s1_hs_q <= s1_hs_d; s1_vs_q <= s1_vs_d; s1_blank_q <= s1_blank_d; s1_pix_q <= s1_pix_d;
      s2_hs_q <= s2_hs_d; s2_vs_q <= s2_vs_d; s2_blank_q <= s2_blank_d;
      state_q <= state_d;
      x_q <= x_d; y_q <= y_d; width_q <= width_d; px_q <= px_d; py_q <= py_d;
      red_q <= red_d; green_q <= green_d; probe_q <= probe_d; gerr_q <= gerr_d;
      res_valid_q <= res_valid_d; res_gerr_q <= res_gerr_d; res_ovr_q <= res_ovr_d;
      res_width_q <= res_width_d; res_height_q <= res_height_d;
      res_red_q <= res_red_d; res_green_q <= res_green_d; res_probe_q <= res_probe_d;
    end
  end

`ifdef VGA_MON_CRC_EN
  logic [15:0] crc_q, crc_d, crc_nxt, res_crc_q, res_crc_d;

  crc16_px24 u_crc (
    .crc_in  (crc_q),
    .data    (s1_pix_q),
    .crc_out (crc_nxt)
  );

  always_comb begin
    crc_d     = crc_q;
    res_crc_d = res_crc_q;
    case (state_q)
      FRAME:   if (active) crc_d = crc_nxt;
      PUBLISH: begin
        res_crc_d = crc_q;
        crc_d     = CRC_INIT;
      end
      default: crc_d = CRC_INIT;
    endcase
  end

  always_ff @(posedge vclock) begin
    if (!reset_n) begin
      crc_q     <= CRC_INIT;
      res_crc_q <= '0;
    end else begin
      crc_q     <= crc_d;
      res_crc_q <= res_crc_d;
    end
  end

  assign res_crc = res_crc_q;
`else
  assign res_crc = 16'h0;
`endif

  assign res_valid     = res_valid_q;
  assign res_width     = res_width_q;
  assign res_height    = res_height_q;
  assign res_red_cnt   = res_red_q;
  assign res_green_cnt = res_green_q;
  assign res_probe     = res_probe_q;
  assign res_geom_err  = res_gerr_q;
  assign res_overrun   = res_ovr_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_vga_stream_monitor.sv
// Bench for vga_stream_monitor on a scaled raster (40x24 active, 56x30 total) with a
// frame-level reference model; CRC expectations follow VGA_MON_CRC_EN.
module tb_vga_stream_monitor;
  import vga_mon_pkg::*;

  localparam int AW = 40, AH = 24;            // active width / height
  localparam int HS = 6, HBP = 6, LT = 56;    // hsync, back porch, line total
  localparam int VS = 2, VBP = 2, FT = 30;    // vsync lines, back porch lines, frame total
  localparam logic [23:0] RED = 24'hFF_00_00, GREEN = 24'h00_FF_00;
  localparam int K_BLACK = 0, K_BLOB = 1, K_SHORT = 2, K_RAND = 3, K_SINGLE = 4;

  typedef struct {
    logic [10:0] width;
    logic [9:0]  height;
    logic [19:0] red;
    logic [19:0] green;
    logic [23:0] probe;
    logic        gerr;
    logic [15:0] crc;
  } rec_t;

  logic        vclock = 1'b0, reset_n = 1'b0;
  logic        phsync = 1'b1, pvsync = 1'b1, pblank = 1'b1, res_ready = 1'b0;
  logic [23:0] pixel = '0;
  logic [10:0] probe_x = '0;
  logic [9:0]  probe_y = '0;
  logic        res_valid, res_geom_err, res_overrun;
  logic [10:0] res_width;
  logic [9:0]  res_height;
  logic [19:0] res_red_cnt, res_green_cnt;
  logic [23:0] res_probe;
  logic [15:0] res_crc;
  mon_state_e  dbg_state;

  rec_t exp_q[$];
  int   n_checks = 0, n_errors = 0;

  vga_stream_monitor #(.EXP_WIDTH(AW), .EXP_HEIGHT(AH)) dut (
    .vclock(vclock), .reset_n(reset_n), .phsync(phsync), .pvsync(pvsync),
    .pblank(pblank), .pixel(pixel), .probe_x(probe_x), .probe_y(probe_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_width(res_width),
    .res_height(res_height), .res_red_cnt(res_red_cnt), .res_green_cnt(res_green_cnt),
    .res_probe(res_probe), .res_geom_err(res_geom_err), .res_overrun(res_overrun),
    .res_crc(res_crc), .dbg_state(dbg_state)
  );

  always #5 vclock = ~vclock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // CRC-16-CCITT of one 24-bit message appended to a running remainder.
  function automatic logic [15:0] crc_px(input logic [15:0] c, input logic [23:0] p);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      fb = r[15] ^ p[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  function automatic logic [23:0] gen_pixel(input int kind, input int row, input int col);
    int sel;
    case (kind)
      K_BLOB: begin
        if (row >= 4 && row < 20 && col >= 2 && col < 18)  return RED;
        if (row >= 4 && row < 20 && col >= 20 && col < 36) return GREEN;
        return 24'h0;
      end
      K_RAND: begin
        sel = $urandom_range(0, 3);
        if (sel == 1) return RED;
        if (sel == 2) return GREEN;
        if (sel == 3) return 24'($urandom);
        return 24'h0;
      end
      K_SINGLE: return 24'h12_34_56;
      default:  return 24'h0;
    endcase
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, ".valid"},  32'(res_valid), 0);
    chk({tag, ".width"},  32'(res_width), 0);
    chk({tag, ".height"}, 32'(res_height), 0);
    chk({tag, ".red"},    32'(res_red_cnt), 0);
    chk({tag, ".green"},  32'(res_green_cnt), 0);
    chk({tag, ".probe"},  32'(res_probe), 0);
    chk({tag, ".gerr"},   32'(res_geom_err), 0);
    chk({tag, ".ovr"},    32'(res_overrun), 0);
    chk({tag, ".crc"},    32'(res_crc), 0);
    chk({tag, ".state"},  32'(dbg_state), 0);
  endtask

  task automatic check_rec(input string tag, input logic ovr);
    rec_t e;
    e = exp_q.pop_front();
    chk({tag, ".valid"},  32'(res_valid), 1);
    chk({tag, ".width"},  32'(res_width), 32'(e.width));
    chk({tag, ".height"}, 32'(res_height), 32'(e.height));
    chk({tag, ".red"},    32'(res_red_cnt), 32'(e.red));
    chk({tag, ".green"},  32'(res_green_cnt), 32'(e.green));
    chk({tag, ".probe"},  32'(res_probe), 32'(e.probe));
    chk({tag, ".gerr"},   32'(res_geom_err), 32'(e.gerr));
    chk({tag, ".ovr"},    32'(res_overrun), 32'(ovr));
    chk({tag, ".crc"},    32'(res_crc), 32'(e.crc));
  endtask

  task automatic accept(input string tag);
    @(negedge vclock) res_ready = 1'b1;
    @(negedge vclock) res_ready = 1'b0;
    chk({tag, ".drop"}, 32'(res_valid), 0);
  endtask

  // Drives one full frame and builds its expected record from the pixels sent.
  task automatic drive_frame(input int kind, input int rst_line, input bit ready_pulse);
    int          w[AH];
    int          yi, r, col;
    logic [23:0] p;
    rec_t        m;
    bit          rst_pend;
    for (int a = 0; a < AH; a++) begin
      w[a] = AW;
      if (kind == K_SHORT && a == 10) w[a] = 34;
      if (kind == K_SINGLE) w[a] = (a == 5) ? 1 : 0;
      if (kind == K_RAND) begin
        r = $urandom_range(0, 9);
        if (r == 0)      w[a] = 0;
        else if (r == 1) w[a] = $urandom_range(1, AW - 1);
      end
    end
    m.width = '0; m.height = '0; m.red = '0; m.green = '0; m.probe = '0;
    m.gerr = 1'b0; m.crc = 16'hFFFF;
    yi = 0; rst_pend = 1'b0;
    for (int l = 0; l < FT; l++) begin
      for (int cyc = 0; cyc < LT; cyc++) begin
        @(negedge vclock);
        if (rst_pend) begin
          reset_n  = 1'b1;
          rst_pend = 1'b0;
          check_zero("mid_reset");
        end
        if (l == rst_line && cyc == 0) begin
          reset_n  = 1'b0;
          rst_pend = 1'b1;
        end
        res_ready = ready_pulse && l == 0 && cyc == 2;
        phsync = (cyc >= HS);
        pvsync = (l >= VS);
        pblank = 1'b1;
        pixel  = 24'($urandom);
        col    = cyc - HS - HBP;
        if (l >= VS + VBP && l < VS + VBP + AH && col >= 0 && col < w[l - VS - VBP]) begin
          p      = gen_pixel(kind, l - VS - VBP, col);
          pblank = 1'b0;
          pixel  = p;
          if (p == RED)   m.red   = m.red + 20'd1;
          if (p == GREEN) m.green = m.green + 20'd1;
          if (col == int'(probe_x) && yi == int'(probe_y)) m.probe = p;
          m.crc = crc_px(m.crc, p);
        end
      end
      if (l >= VS + VBP && l < VS + VBP + AH && w[l - VS - VBP] > 0) begin
        yi++;
        m.width = 11'(w[l - VS - VBP]);
        if (w[l - VS - VBP] != AW) m.gerr = 1'b1;
      end
    end
    m.height = 10'(yi);
    if (yi != AH) m.gerr = 1'b1;
`ifndef VGA_MON_CRC_EN
    m.crc = 16'h0;
`endif
    if (rst_line >= 0) void'(exp_q.pop_front());
    else               exp_q.push_back(m);
  endtask

  initial begin
    repeat (3) @(negedge vclock);
    check_zero("reset_hold");
    reset_n = 1'b1;
    repeat (4) @(negedge vclock);
    check_zero("after_reset");

    probe_x = 11'd10; probe_y = 10'd10;
    drive_frame(K_BLACK, -1, 1'b0);
    chk("first_edge.valid", 32'(res_valid), 0);
    drive_frame(K_BLACK, -1, 1'b0);
    check_rec("nominal", 1'b0);
    accept("nominal");
    drive_frame(K_BLOB, -1, 1'b0);
    check_rec("nominal2", 1'b0);
    accept("nominal2");
    drive_frame(K_SHORT, -1, 1'b0);
    check_rec("blobs", 1'b0);
    accept("blobs");
    drive_frame(K_BLACK, -1, 1'b0);
    check_rec("short_line", 1'b0);
    accept("short_line");

    probe_x = 11'd45; probe_y = 10'd3;
    drive_frame(K_RAND, -1, 1'b0);
    check_rec("clean_after_short", 1'b0);
    probe_x = 11'($urandom_range(0, 44)); probe_y = 10'($urandom_range(0, 27));
    drive_frame(K_RAND, -1, 1'b0);
    check_rec("overrun", 1'b1);
    probe_x = 11'($urandom_range(0, 44)); probe_y = 10'($urandom_range(0, 27));
    drive_frame(K_RAND, -1, 1'b1);
    check_rec("accept_at_publish", 1'b0);

    drive_frame(K_RAND, 15, 1'b0);
    probe_x = 11'($urandom_range(0, 39)); probe_y = 10'($urandom_range(0, 23));
    drive_frame(K_RAND, -1, 1'b0);
    chk("post_reset_edge.valid", 32'(res_valid), 0);
    chk("post_reset_edge.state", 32'(dbg_state), 32'(FRAME));
    probe_x = 11'd0; probe_y = 10'd0;
    drive_frame(K_SINGLE, -1, 1'b0);
    check_rec("post_reset_frame", 1'b0);
    accept("post_reset_frame");
    drive_frame(K_BLACK, -1, 1'b0);
    check_rec("single_pixel", 1'b0);
    accept("single_pixel");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
